// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one sram-like memory port between the instruction-fetch requester
//   (inst_*) and the load/store requester (data_*). One address handshake is
//   granted per cycle. A small in-order ID FIFO remembers which requester
//   issued each accepted transaction, so every mem_data_ok/mem_rdata is routed
//   back to its issuer. Address and data paths are combinational pass-through.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   inst_* (req..wdata)    fetch request channel, inst_addr_ok/data_ok/rdata back
//   data_* (req..wdata)    load/store request channel, data_addr_ok/data_ok/rdata back
//   mem_*  (req..wdata)    forwarded request to the memory bridge
//   mem_addr_ok            bridge accepted the current address
//   mem_data_ok, mem_rdata bridge completed the oldest outstanding transaction
//   arb_err                sticky: mem_data_ok seen with nothing outstanding
//
// Grant-lock FSM
//   state        | meaning
//   ST_FREE      | no stalled request; data_req wins, else inst
//   ST_LOCK_INST | inst request presented but not yet accepted; grant pinned to inst
//   ST_LOCK_DATA | data request presented but not yet accepted; grant pinned to data
module mem_req_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int ID_FIFO_AW  = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        arb_err
);

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } state_t;

    localparam logic [ID_FIFO_AW:0] CNT_FULL = (ID_FIFO_AW + 1)'(OUTSTANDING);

    state_t                  state;
    state_t                  state_nxt;

    logic                    grant_data;
    logic                    grant_req;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    head_id;

    logic [ID_FIFO_AW:0]     count;
    logic [ID_FIFO_AW-1:0]   wr_ptr;
    logic [ID_FIFO_AW-1:0]   rd_ptr;
    // One bit per slot: 0 = inst, 1 = data.
    logic [OUTSTANDING-1:0]  id_mem;

    assign fifo_full = (count == CNT_FULL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        grant_data   = 1'b0;
        grant_req    = 1'b0;
        mem_req      = 1'b0;
        state_nxt    = ST_FREE;

        case (state)
            ST_LOCK_INST: grant_data = 1'b0;
            ST_LOCK_DATA: grant_data = 1'b1;
            default:      grant_data = data_req;
        endcase

        grant_req = grant_data ? data_req : inst_req;
        mem_req   = grant_req & ~fifo_full;

        // A presented-but-refused request pins the grant so the payload seen by
        // the bridge cannot switch underneath it. Acceptance (or the request
        // going away) releases the lock.
        if (mem_req && !mem_addr_ok) begin
            state_nxt = grant_data ? ST_LOCK_DATA : ST_LOCK_INST;
        end
    end

    // Payload follows the grant even when mem_req is low; inputs are defined
    // out of reset so the mux never produces X on its own.
    assign mem_wr    = grant_data ? data_wr    : inst_wr;
    assign mem_size  = grant_data ? data_size  : inst_size;
    assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = grant_data ? data_addr  : inst_addr;
    assign mem_wdata = grant_data ? data_wdata : inst_wdata;

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & (count != '0);

    assign inst_addr_ok = push & ~grant_data;
    assign data_addr_ok = push &  grant_data;

    assign head_id      = id_mem[rd_ptr];
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop &  head_id;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= grant_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arb_err <= 1'b0;
        end else if (mem_data_ok && (count == '0)) begin
            arb_err <= 1'b1;
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one sram-like memory port between the core's instruction-fetch requester and its load/store requester.
- Protocol on all ports is the same: req, wr, size, wstrb, addr, wdata, addr_ok, data_ok, rdata.
- Sits between the CPU core and the memory-side bridge.
- Grants one address handshake per cycle and tracks outstanding transactions in order, so each data_ok/rdata returns to the requester that issued it.

Parameters:
- OUTSTANDING, 4, max in-flight transactions (address accepted, data_ok pending); power of 2, >=2.
- ID_FIFO_AW, 2, log2(OUTSTANDING).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request
- inst_wr  in  1  write flag (fetch drives 0)
- inst_size  in  2  0:byte 1:half 2:word
- inst_wstrb  in  4  byte strobes
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch transaction complete
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  write flag
- data_size  in  2  size
- data_wstrb  in  4  strobes
- data_addr  in  32  address
- data_wdata  in  32  write data
- data_addr_ok  out  1  load/store address accepted
- data_data_ok  out  1  load/store complete
- data_rdata  out  32  load data
- mem_req  out  1  request to memory bridge
- mem_wr  out  1  forwarded wr
- mem_size  out  2  forwarded size
- mem_wstrb  out  4  forwarded wstrb
- mem_addr  out  32  forwarded addr
- mem_wdata  out  32  forwarded wdata
- mem_addr_ok  in  1  bridge accepted address
- mem_data_ok  in  1  bridge completed oldest transaction
- mem_rdata  in  32  read data for oldest transaction
- arb_err  out  1  sticky protocol error

Behaviour:
- Reset (resetn=0, async): ID FIFO empty (count=0, pointers 0), lock cleared, arb_err=0. All combinational outputs are therefore 0 while no requests are present. In-flight transactions are discarded; the bridge must also be reset.
- Free selection (lock clear): data_req wins over inst_req. The grant goes to inst only when data_req=0. Fetch starvation is accepted; the pipeline guarantees data_req eventually drops.
- Grant lock: if mem_req=1 and mem_addr_ok=0 at a clock edge, register lock=1 and lock_src=current grant. While locked, the grant is fixed to lock_src regardless of new requests, so mem_* payload stays stable until accept. The lock clears on the cycle mem_addr_ok=1.
- Requesters hold req and payload until their addr_ok; the arbiter does not check this.
- mem_req = (granted requester's req) & (count < OUTSTANDING). mem_wr/size/wstrb/addr/wdata mux from the granted requester. When mem_req=0 the payload is don't-care but must not be X when reset.
- Address ack: inst_addr_ok = mem_req & mem_addr_ok & grant==inst. data_addr_ok is the same for data. At most one is high per cycle.
- Push: on mem_req & mem_addr_ok, push source ID (0=inst, 1=data) into the ID FIFO at the next edge.
- Return: on mem_data_ok with count>0, the head ID selects the target. inst_data_ok or data_data_ok = mem_data_ok in the same cycle (combinational). inst_rdata and data_rdata both equal mem_rdata. Pop the head at the edge.
- Writes also complete with one data_ok; rdata is ignored by the requester.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at count=OUTSTANDING because mem_req is gated by count<OUTSTANDING, so no push occurs that cycle. A pop at full unblocks the next cycle.
- Pointer wrap: modulo OUTSTANDING. count is ID_FIFO_AW+1 bits.
- mem_data_ok with count=0: no *_data_ok asserted, FIFO unchanged, arb_err set to 1 and held until reset.
- Lock while the FIFO becomes full cannot occur, since count rises only on accept, which clears the lock. Lock with count decreasing is fine.
- Latency: zero added cycles on both address and data paths (combinational pass-through).

Test Plan:
- Single fetch: inst_req=1 addr=0x1c000000, mem_addr_ok=1 same cycle → inst_addr_ok=1, mem_addr=0x1c000000. Two cycles later mem_data_ok=1, mem_rdata=0x02800c0c → inst_data_ok=1, inst_rdata=0x02800c0c, data_data_ok=0.
- Contention: inst_req and data_req both 1 (data_addr=0x80), mem_addr_ok=1 → data_addr_ok=1, mem_addr=0x80. Next cycle inst granted. Returns come data then inst, matching issue order.
- Lock: inst_req alone, mem_addr_ok=0 for 3 cycles; data_req rises in cycle 2 → mem_addr stays at inst_addr through all 3 cycles. When mem_addr_ok=1, inst_addr_ok=1. Next cycle data is granted.
- Full: 4 accepts with no data_ok → count=4. 5th request sees mem_req=0. mem_data_ok=1 → head routed, and mem_req=1 the following cycle.
- Push and pop in the same cycle at count=2 → count stays 2. Over 8 mixed transactions, IDs route correctly through pointer wrap.
- Spurious mem_data_ok at count=0 → no data_ok outputs, arb_err=1 and remains set. resetn=0 mid-stream → arb_err=0, count=0 asynchronously.
